// File: rtl/sprf_idx_burst_seq.sv
`default_nettype none
// ============================================================================
// Module   : sprf_idx_burst_seq
// Purpose  : Sequencer for SPRF-indexed DMEM bursts. Loads a start index,
//            a length and a stride, then issues one DMEM address per enabled
//            cycle (read strobes for src-indirect bursts, write strobes for
//            dst-indirect bursts). After the burst it writes the
//            post-incremented index back to the SPRF and pulses done.
// Optional : Define SPRF_SEQ_ABORT_EN to add the ipt_abort input. Abort
//            cancels an in-flight burst with no write-back and no done pulse.
// Ports    :
//   clk            in   system clock, rising edge
//   reset          in   synchronous active-high reset
//   t_cs           in   global advance enable (low = freeze all state)
//   ipt_start      in   burst request (ignored while busy)
//   ipt_dir_wr     in   0 = read burst, 1 = write burst
//   ipt_base_idx   in   start index; only the low ADDR_W bits are used
//   ipt_len        in   number of accesses (0 = write-back only)
//   ipt_stride     in   address increment per access
//   ipt_abort      in   (SPRF_SEQ_ABORT_EN only) cancel burst
//   opt_busy       out  high in any state other than IDLE
//   opt_dram_addr  out  DMEM address while issuing, 0 otherwise
//   opt_dram_rd_en out  DMEM read strobe
//   opt_dram_wr_en out  DMEM write strobe
//   opt_idx_wb_en  out  SPRF index write-back strobe
//   opt_idx_wb_dat out  updated index, zero-extended from ADDR_W
//   opt_done       out  one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module sprf_idx_burst_seq #(
    parameter int ADDR_W = 11,
    parameter int IDX_W  = 16,
    parameter int LEN_W  = 8,
    parameter int STR_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              t_cs,
    input  logic              ipt_start,
    input  logic              ipt_dir_wr,
    input  logic [IDX_W-1:0]  ipt_base_idx,
    input  logic [LEN_W-1:0]  ipt_len,
    input  logic [STR_W-1:0]  ipt_stride,
`ifdef SPRF_SEQ_ABORT_EN
    input  logic              ipt_abort,
`endif
    output logic              opt_busy,
    output logic [ADDR_W-1:0] opt_dram_addr,
    output logic              opt_dram_rd_en,
    output logic              opt_dram_wr_en,
    output logic              opt_idx_wb_en,
    output logic [IDX_W-1:0]  opt_idx_wb_dat,
    output logic              opt_done
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ISSUE = 2'd1;
    localparam logic [1:0] c_ST_WB    = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [LEN_W-1:0]  cnt_q,   cnt_d;
    logic [STR_W-1:0]  str_q,   str_d;
    logic              dir_q,   dir_d;

    logic              w_abort;
    logic [ADDR_W-1:0] w_str_ext;
    logic [IDX_W-1:0]  w_wb_dat;
    logic              w_unused_base;

    // Index bits above ADDR_W are architecturally ignored.
    assign w_unused_base = &{1'b0, ipt_base_idx};

`ifdef SPRF_SEQ_ABORT_EN
    assign w_abort = ipt_abort;
`else
    assign w_abort = 1'b0;
`endif

    // Zero-extend the stride to the address width; the sum then wraps
    // modulo 2^ADDR_W without any explicit masking.
    always_comb begin
        w_str_ext              = '0;
        w_str_ext[STR_W-1:0]   = str_q;
    end

    always_comb begin
        w_wb_dat               = '0;
        w_wb_dat[ADDR_W-1:0]   = addr_q;
    end

    // ------------------------------------------------------------------
    // Next-state logic. Computed as if the cycle advances; the register
    // block only commits it on edges where t_cs is high.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        str_d   = str_q;
        dir_d   = dir_q;
        case (state_q)
            c_ST_IDLE: begin
                if (ipt_start) begin
                    addr_d  = ipt_base_idx[ADDR_W-1:0];
                    cnt_d   = ipt_len;
                    str_d   = ipt_stride;
                    dir_d   = ipt_dir_wr;
                    // A zero-length burst still writes back the base index.
                    state_d = (ipt_len != '0) ? c_ST_ISSUE : c_ST_WB;
                end
            end
            c_ST_ISSUE: begin
                addr_d = addr_q + w_str_ext;
                cnt_d  = cnt_q - LEN_W'(1);
                // Abort takes priority over the last-access transition.
                if (w_abort) begin
                    state_d = c_ST_IDLE;
                end else if (cnt_q == LEN_W'(1)) begin
                    state_d = c_ST_WB;
                end
            end
            c_ST_WB: begin
                state_d = c_ST_IDLE;
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= c_ST_IDLE;
            addr_q  <= '0;
            cnt_q   <= '0;
            str_q   <= '0;
            dir_q   <= 1'b0;
        end else if (t_cs) begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            str_q   <= str_d;
            dir_q   <= dir_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registered state. Strobes are qualified with
    // t_cs so a frozen cycle issues nothing while the address holds.
    // ------------------------------------------------------------------
    always_comb begin
        opt_busy       = (state_q != c_ST_IDLE);
        opt_dram_addr  = '0;
        opt_dram_rd_en = 1'b0;
        opt_dram_wr_en = 1'b0;
        opt_idx_wb_en  = 1'b0;
        opt_idx_wb_dat = '0;
        opt_done       = 1'b0;
        if (state_q == c_ST_ISSUE) begin
            opt_dram_addr  = addr_q;
            opt_dram_rd_en = t_cs & ~dir_q;
            opt_dram_wr_en = t_cs &  dir_q;
        end
        if (state_q == c_ST_WB) begin
            // An abort landing on the write-back cycle cancels it as well.
            opt_idx_wb_en  = t_cs & ~w_abort;
            opt_idx_wb_dat = w_wb_dat;
            opt_done       = t_cs & ~w_abort;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sprf_idx_burst_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sprf_idx_burst_seq
// Purpose  : Self-checking bench for sprf_idx_burst_seq. Expected strobes
//            (kind + address/data) are queued when a burst is started and
//            popped by a negedge monitor whenever the DUT strobes.
//            Define SPRF_SEQ_ABORT_EN to also exercise the abort input.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sprf_idx_burst_seq;

    localparam logic [1:0] c_K_RD = 2'd0;
    localparam logic [1:0] c_K_WR = 2'd1;
    localparam logic [1:0] c_K_WB = 2'd2;

    logic        clk = 1'b0;
    logic        reset;
    logic        t_cs;
    logic        ipt_start;
    logic        ipt_dir_wr;
    logic [15:0] ipt_base_idx;
    logic [7:0]  ipt_len;
    logic [3:0]  ipt_stride;
`ifdef SPRF_SEQ_ABORT_EN
    logic        ipt_abort;
`endif
    logic        opt_busy;
    logic [10:0] opt_dram_addr;
    logic        opt_dram_rd_en;
    logic        opt_dram_wr_en;
    logic        opt_idx_wb_en;
    logic [15:0] opt_idx_wb_dat;
    logic        opt_done;

    int          n_assert = 0;
    int          n_fail   = 0;
    logic        mon_en   = 1'b0;
    logic [17:0] exp_q[$];

    sprf_idx_burst_seq dut (
        .clk            (clk),
        .reset          (reset),
        .t_cs           (t_cs),
        .ipt_start      (ipt_start),
        .ipt_dir_wr     (ipt_dir_wr),
        .ipt_base_idx   (ipt_base_idx),
        .ipt_len        (ipt_len),
        .ipt_stride     (ipt_stride),
`ifdef SPRF_SEQ_ABORT_EN
        .ipt_abort      (ipt_abort),
`endif
        .opt_busy       (opt_busy),
        .opt_dram_addr  (opt_dram_addr),
        .opt_dram_rd_en (opt_dram_rd_en),
        .opt_dram_wr_en (opt_dram_wr_en),
        .opt_idx_wb_en  (opt_idx_wb_en),
        .opt_idx_wb_dat (opt_idx_wb_dat),
        .opt_done       (opt_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [15:0] val);
        exp_q.push_back({kind, val});
    endtask

    // Drives a start request for exactly one edge; on return the DUT is in
    // the first cycle after acceptance.
    task automatic start_burst(input logic [15:0] base, input logic [7:0] len,
                               input logic [3:0] stride, input logic dir);
        ipt_base_idx = base;
        ipt_len      = len;
        ipt_stride   = stride;
        ipt_dir_wr   = dir;
        ipt_start    = 1'b1;
        step();
        ipt_start    = 1'b0;
    endtask

    // Monitor: every strobe must match the head of the expectation queue.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [1:0]  k;
            logic [15:0] v;
            logic [17:0] e;
            n_assert++;
            assert ((opt_dram_rd_en & opt_dram_wr_en) === 1'b0) else begin
                n_fail++;
                $error("FAIL rd_wr_exclusive observed=%b%b expected=not both", opt_dram_rd_en, opt_dram_wr_en);
            end
            n_assert++;
            assert (opt_done === opt_idx_wb_en) else begin
                n_fail++;
                $error("FAIL done_with_wb observed=%b expected=%b", opt_done, opt_idx_wb_en);
            end
            if (opt_dram_rd_en || opt_dram_wr_en || opt_idx_wb_en) begin
                k = opt_idx_wb_en ? c_K_WB : (opt_dram_wr_en ? c_K_WR : c_K_RD);
                v = opt_idx_wb_en ? opt_idx_wb_dat : {5'd0, opt_dram_addr};
                if (exp_q.size() == 0) begin
                    n_assert++;
                    n_fail++;
                    $error("FAIL unexpected_strobe observed=kind%0d/%0h expected=none", k, v);
                end else begin
                    e = exp_q.pop_front();
                    n_assert++;
                    assert ({k, v} === e) else begin
                        n_fail++;
                        $error("FAIL strobe observed=kind%0d/%0h expected=kind%0d/%0h", k, v, e[17:16], e[15:0]);
                    end
                end
            end
        end
    end

    initial begin
        reset        = 1'b1;
        t_cs         = 1'b1;
        ipt_start    = 1'b0;
        ipt_dir_wr   = 1'b0;
        ipt_base_idx = '0;
        ipt_len      = '0;
        ipt_stride   = '0;
`ifdef SPRF_SEQ_ABORT_EN
        ipt_abort    = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
        chk("reset_busy",   {31'd0, opt_busy},       32'd0);
        chk("reset_addr",   {21'd0, opt_dram_addr},  32'd0);
        chk("reset_strobe", {29'd0, opt_dram_rd_en, opt_dram_wr_en, opt_idx_wb_en}, 32'd0);
        chk("reset_done",   {31'd0, opt_done},       32'd0);
        chk("reset_wbdat",  {16'd0, opt_idx_wb_dat}, 32'd0);
        mon_en = 1'b1;

        // Basic read burst: 4 accesses then write-back in cycle N+L+1.
        push(c_K_RD, 16'h0010); push(c_K_RD, 16'h0012);
        push(c_K_RD, 16'h0014); push(c_K_RD, 16'h0016);
        push(c_K_WB, 16'h0018);
        start_burst(16'h0010, 8'd4, 4'd2, 1'b0);
        chk("rd_first_addr", {21'd0, opt_dram_addr}, 32'h010);
        chk("rd_busy",       {31'd0, opt_busy},      32'd1);
        repeat (4) step();
        chk("rd_done_lat",   {31'd0, opt_done},      32'd1);
        step();
        chk("rd_idle",       {31'd0, opt_busy},      32'd0);

        // Write burst with a two-cycle stall after the first access.
        push(c_K_WR, 16'h0100); push(c_K_WR, 16'h0101);
        push(c_K_WR, 16'h0102); push(c_K_WB, 16'h0103);
        start_burst(16'h0100, 8'd3, 4'd1, 1'b1);
        step();
        t_cs = 1'b0;
        #1;
        chk("stall1_addr", {21'd0, opt_dram_addr},  32'h101);
        chk("stall1_wr",   {31'd0, opt_dram_wr_en}, 32'd0);
        step();
        chk("stall2_addr", {21'd0, opt_dram_addr},  32'h101);
        chk("stall2_busy", {31'd0, opt_busy},       32'd1);
        step();
        t_cs = 1'b1;
        step();
        step();
        chk("wr_done", {31'd0, opt_done}, 32'd1);
        step();

        // Zero length: write-back of unchanged base, busy for one cycle.
        push(c_K_WB, 16'h0055);
        start_burst(16'h0055, 8'd0, 4'd3, 1'b0);
        chk("zl_done", {31'd0, opt_done}, 32'd1);
        chk("zl_addr", {21'd0, opt_dram_addr}, 32'd0);
        step();
        chk("zl_idle", {31'd0, opt_busy}, 32'd0);

        // Wrap-around at 2^ADDR_W; upper index bits are ignored.
        push(c_K_RD, 16'h07FE); push(c_K_RD, 16'h07FF);
        push(c_K_RD, 16'h0000); push(c_K_WB, 16'h0001);
        start_burst(16'hA7FE, 8'd3, 4'd1, 1'b0);
        repeat (4) step();

        // Stride 0 repeats the address; maximum stride.
        push(c_K_WR, 16'h0003); push(c_K_WR, 16'h0003); push(c_K_WB, 16'h0003);
        start_burst(16'h0003, 8'd2, 4'd0, 1'b1);
        repeat (3) step();
        push(c_K_RD, 16'h07F0); push(c_K_RD, 16'h07FF); push(c_K_WB, 16'h000E);
        start_burst(16'h07F0, 8'd2, 4'd15, 1'b0);
        repeat (3) step();

        // Start while busy is ignored, then reset mid-burst.
        push(c_K_RD, 16'h0200); push(c_K_RD, 16'h0201); push(c_K_RD, 16'h0202);
        start_burst(16'h0200, 8'd8, 4'd1, 1'b0);
        ipt_base_idx = 16'h0300;
        ipt_len      = 8'd1;
        ipt_dir_wr   = 1'b1;
        ipt_start    = 1'b1;
        step();
        ipt_start = 1'b0;
        chk("busy_start_addr", {21'd0, opt_dram_addr},  32'h201);
        chk("busy_start_rd",   {31'd0, opt_dram_rd_en}, 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("midrst_busy", {31'd0, opt_busy}, 32'd0);
        chk("midrst_strb", {29'd0, opt_dram_rd_en, opt_dram_wr_en, opt_idx_wb_en}, 32'd0);
        chk("midrst_addr", {21'd0, opt_dram_addr}, 32'd0);
        repeat (10) step();

        // Recovery after reset.
        push(c_K_WR, 16'h0042); push(c_K_WB, 16'h0043);
        start_burst(16'h0042, 8'd1, 4'd1, 1'b1);
        repeat (2) step();

`ifdef SPRF_SEQ_ABORT_EN
        // Abort on the third ISSUE cycle: three strobes, no write-back.
        push(c_K_RD, 16'h0020); push(c_K_RD, 16'h0021); push(c_K_RD, 16'h0022);
        start_burst(16'h0020, 8'd5, 4'd1, 1'b0);
        step();
        step();
        ipt_abort = 1'b1;
        step();
        ipt_abort = 1'b0;
        chk("abort_idle", {31'd0, opt_busy}, 32'd0);
        repeat (8) step();
`endif

        chk("queue_empty", exp_q.size(), 32'd0);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sprf_idx_burst_seq.md
Name: sprf_idx_burst_seq

Overview:
- Sequencer for SPRF-indexed DMEM accesses.
- Takes a start index from the SPRF, a length and a stride, then issues one DMEM address per enabled cycle (read for src-indirect, write for dst-indirect).
- Writes the post-incremented index back to the SPRF and pulses done.
- Sits between ins_decoder, SPRF and dmem_wrapper, replacing single-shot indirect addressing for vector operations.

Parameters:
- ADDR_W, 11, DMEM address width (matches DMEMADDRW).
- IDX_W, 16, SPRF data width (matches SPRF_DAT_W); must be >= ADDR_W.
- LEN_W, 8, burst length counter width.
- STR_W, 4, stride width (unsigned).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- t_cs  input  1  global advance enable; when low, all state frozen.
- ipt_start  input  1  burst request from ins_decoder.
- ipt_dir_wr  input  1  0 = read burst (src indirect), 1 = write burst (dst indirect); sampled with start.
- ipt_base_idx  input  IDX_W  start index from SPRF; only bits [ADDR_W-1:0] are used.
- ipt_len  input  LEN_W  number of accesses; 0 = none.
- ipt_stride  input  STR_W  address increment per access.
- opt_busy  output  1  high in any state other than IDLE.
- opt_dram_addr  output  ADDR_W  DMEM address; 0 when not issuing.
- opt_dram_rd_en  output  1  read strobe.
- opt_dram_wr_en  output  1  write strobe.
- opt_idx_wb_en  output  1  SPRF index write-back strobe.
- opt_idx_wb_dat  output  IDX_W  updated index, zero-extended from ADDR_W.
- opt_done  output  1  one-cycle completion pulse.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state = IDLE; addr_reg = 0, cnt = 0, dir = 0.
  - All outputs 0.
  - Reset mid-burst abandons the burst with no write-back and no done.
- States: IDLE, ISSUE, WB.
  - Transitions are evaluated only on edges where t_cs = 1.
  - With t_cs = 0, all registers hold and opt_dram_rd_en, opt_dram_wr_en, opt_idx_wb_en and opt_done are forced to 0; opt_dram_addr holds its value.
- IDLE:
  - Acceptance occurs on an edge with ipt_start & t_cs = 1. On acceptance: addr_reg <= ipt_base_idx[ADDR_W-1:0], cnt <= ipt_len, str <= ipt_stride, dir <= ipt_dir_wr.
  - If ipt_len != 0, go to ISSUE; if ipt_len == 0, go to WB (write-back of unchanged base).
- ISSUE (combinational outputs from registers):
  - opt_dram_addr = addr_reg.
  - opt_dram_rd_en = t_cs & ~dir; opt_dram_wr_en = t_cs & dir.
  - Each t_cs edge: addr_reg <= addr_reg + str, modulo 2^ADDR_W (wraps silently); cnt <= cnt - 1.
  - When cnt == 1 on that edge, go to WB.
- WB:
  - opt_idx_wb_en = t_cs; opt_idx_wb_dat = {0, addr_reg}; opt_done = t_cs.
  - Next t_cs edge: go to IDLE.
- Latency:
  - Start accepted at edge N; first address visible in cycle N+1.
  - With t_cs constantly high, a burst of length L occupies L ISSUE cycles plus 1 WB cycle, and opt_done is high in cycle N+L+1.
  - The next start can be accepted at the WB->IDLE edge + 1.
- ipt_start while busy is ignored (not queued).
- Stride 0 is legal: the same address is repeated L times.
- Length 2^LEN_W - 1 is the maximum burst.
- Read and write strobes are never both high.

Optional Feature:
- Macro SPRF_SEQ_ABORT_EN.
- When defined:
  - Adds input ipt_abort (1 bit).
  - ipt_abort = 1 on a t_cs edge in ISSUE or WB forces IDLE.
  - No write-back and no done pulse; the strobe in that same cycle is still driven normally.
  - Abort in IDLE has no effect.
  - Abort outranks a simultaneous cnt == 1 transition.
- When undefined: port absent; a burst always runs to completion except on reset.

Test Plan:
- Basic read burst:
  - Stimulus: base = 0x0010, len = 4, stride = 2, dir = 0, t_cs = 1.
  - Response: rd_en addresses 0x010, 0x012, 0x014, 0x016 on consecutive cycles, then wb_en with dat = 0x0018 and done pulse; wr_en never high.
- Write burst with stall:
  - Stimulus: base = 0x0100, len = 3, stride = 1, dir = 1; t_cs low for 2 cycles after the 1st access.
  - Response: addresses 0x100, [held, no strobe] x2, 0x101, 0x102; wb dat = 0x0103.
- Zero length:
  - Stimulus: base = 0x0055, len = 0.
  - Response: no strobes; next cycle wb_en = 1, dat = 0x0055, done = 1; total busy 1 cycle.
- Wrap-around:
  - Stimulus: base = 0x07FE, len = 3, stride = 1, ADDR_W = 11.
  - Response: addresses 0x7FE, 0x7FF, 0x000; wb dat = 0x0001.
- Start while busy and reset mid-burst:
  - Stimulus: start pulsed during ISSUE, then reset asserted during a len = 8 burst.
  - Response: second start ignored; after reset, busy = 0, all strobes 0, no done/wb.
- Abort (SPRF_SEQ_ABORT_EN):
  - Stimulus: len = 5, abort on 3rd ISSUE cycle.
  - Response: 3 strobes issued, IDLE next cycle, wb_en and done never asserted.
